// File: rtl/boot_copier.sv
// boot_copier: copies a 256-byte boot ROM into RAM at DEST_BASE, then releases the CPU.
// Optional running checksum of copied bytes enabled by defining BOOT_COPIER_CHECKSUM_EN.
module boot_copier #(
   parameter logic [15:0] DEST_BASE = 16'hFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        rom_cs,
   output logic [7:0]  rom_addr,
   input  logic [7:0]  rom_dbr,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_dbw,
   output logic        ram_we,
   input  logic        ram_ack,
   output logic        cpu_ready,
   output logic [7:0]  checksum
);
   typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;
   state_t state_q, state_d;
   logic [7:0] idx_q, idx_d, data_q, data_d;
   logic [15:0] ram_addr_q, ram_addr_d;
   // next state; the RAM address is loaded only on the way into WRITE so it holds between writes
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      data_d = data_q;
      ram_addr_d = ram_addr_q;
      case (state_q)
         IDLE: begin
            state_d = READ;
            idx_d = 8'h00;
         end
         READ: state_d = LATCH;
         LATCH: begin
            data_d = rom_dbr;
            ram_addr_d = DEST_BASE + {8'h00, idx_q};
            state_d = WRITE;
         end
         WRITE: if (ram_ack) begin
            state_d = (idx_q == 8'hFF) ? DONE : READ;
            idx_d = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
         end
         DONE: if (start) begin
            state_d = READ;
            idx_d = 8'h00;
         end
         default: state_d = IDLE;
      endcase
   end
   // state, index, data and address registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q <= 8'h00;
         data_q <= 8'h00;
         ram_addr_q <= DEST_BASE;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         data_q <= data_d;
         ram_addr_q <= ram_addr_d;
      end
   end
   assign rom_cs = state_q == READ;
   assign rom_addr = idx_q;
   assign ram_we = state_q == WRITE;
   assign ram_addr = ram_addr_q;
   assign ram_dbw = data_q;
   assign cpu_ready = state_q == DONE;
`ifdef BOOT_COPIER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   // running sum of accepted writes, cleared when a restart is accepted
   always_comb sum_d = (state_q == DONE && start) ? 8'h00 : (state_q == WRITE && ram_ack) ? sum_q + data_q : sum_q;
   // checksum accumulator register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sum_q <= 8'h00;
      else sum_q <= sum_d;
   end
   assign checksum = sum_q;
`else
   assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: table-driven copy scenarios with randomized ROM data, ack stalls and stray inputs.
module tb_boot_copier;
   localparam logic [15:0] B0 = 16'hFF00;
   localparam logic [15:0] B1 = 16'h0200;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, ram_ack = 1'b0;
   logic [7:0] rom_dbr = 8'h00;
   logic rom_cs, ram_we, cpu_ready, rom_cs1, ram_we1, cpu_ready1;
   logic [7:0] rom_addr, ram_dbw, checksum, rom_addr1, ram_dbw1, checksum1;
   logic [15:0] ram_addr, ram_addr1;
   int checks = 0, failures = 0;
   logic [7:0] rom [256];
   logic [7:0] ram [256];
   int stall [256];

   boot_copier #(.DEST_BASE(B0)) u0 (.clk(clk), .rst(rst), .start(start), .rom_cs(rom_cs), .rom_addr(rom_addr),
      .rom_dbr(rom_dbr), .ram_addr(ram_addr), .ram_dbw(ram_dbw), .ram_we(ram_we), .ram_ack(ram_ack),
      .cpu_ready(cpu_ready), .checksum(checksum));
   boot_copier #(.DEST_BASE(B1)) u1 (.clk(clk), .rst(rst), .start(start), .rom_cs(rom_cs1), .rom_addr(rom_addr1),
      .rom_dbr(rom_dbr), .ram_addr(ram_addr1), .ram_dbw(ram_dbw1), .ram_we(ram_we1), .ram_ack(ram_ack),
      .cpu_ready(cpu_ready1), .checksum(checksum1));

   always #5 clk = ~clk;

   typedef struct {
      bit via_start;
      int pat;
      int stall_mode;
      bit rand_start;
      int abort_at;
      int exp_cycles;
      int exp_sum;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rom_cs"}, rom_cs, 0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_addr"}, ram_addr, B0);
      chk({tag, "_ram_dbw"}, ram_dbw, 0);
      chk({tag, "_cpu_ready"}, cpu_ready, 0);
      chk({tag, "_checksum"}, checksum, 0);
      chk({tag, "_u1_ram_addr"}, ram_addr1, B1);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      ram_ack = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
   endtask

   task automatic load(input vec_t v, output int exp_cycles, output int exp_sum);
      int s = 0, tot = 0;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = i[7:0];
         rom[i] = (v.pat == 0) ? (b ^ 8'hA5) : (v.pat == 1) ? 8'h01 : (v.pat == 2) ? ((i == 0) ? 8'h10 : 8'h00) : 8'($urandom);
         ram[i] = ~rom[i];
         stall[i] = (v.stall_mode == 1) ? ((i == 7) ? 5 : 0) : (v.stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
         s += stall[i];
         tot += rom[i];
      end
      exp_cycles = (v.exp_cycles < 0) ? 769 + s : v.exp_cycles;
      exp_sum = (v.exp_sum < 0) ? tot % 256 : v.exp_sum;
   endtask

   task automatic run_copy(input vec_t v);
      int k = 0, w = 0, cyc = 0, exp_cycles, exp_sum;
      bit pend = 0, done = 0;
      logic [7:0] paddr = 0, pro;
      logic [15:0] pra;
      load(v, exp_cycles, exp_sum);
      pra = v.via_start ? B0 + 16'd255 : B0;
      pro = v.via_start ? 8'hFF : 8'h00;
      while (!done && cyc < exp_cycles + 20) begin
         @(negedge clk);
         cyc++;
         rom_dbr = pend ? rom[paddr] : 8'($urandom);
         pend = rom_cs;
         paddr = rom_addr;
         if (cpu_ready) begin
            done = 1;
            start = 1'b0;
         end else begin
            start = v.rand_start ? 1'($urandom) : 1'b0;
            if (rom_cs) chk("rom_addr", rom_addr, k);
            else chk("rom_addr_hold", rom_addr, pro);
            pro = rom_addr;
            if (ram_we1) chk("u1_ram_addr", ram_addr1, B1 + 16'(k));
            if (ram_we) begin
               chk("no_write_past_end", k < 256, 1);
               chk("ram_addr", ram_addr, B0 + 16'(k));
               chk("ram_dbw", ram_dbw, rom[k[7:0]]);
               if (k == v.abort_at) begin
                  #1 rst = 1'b1;
                  ram_ack = 1'b0;
                  start = 1'b0;
                  #1 chk_reset_outputs("abort");
                  return;
               end
               ram_ack = w >= stall[k[7:0]];
               if (ram_ack) begin
                  ram[k[7:0]] = ram_dbw;
                  k++;
                  w = 0;
               end else w++;
            end else begin
               chk("ram_addr_hold", ram_addr, pra);
               ram_ack = 1'($urandom);
            end
            pra = ram_addr;
         end
      end
      chk("done_cycles", cyc, exp_cycles);
      chk("bytes_written", k, 256);
`ifdef BOOT_COPIER_CHECKSUM_EN
      chk("checksum", checksum, exp_sum);
      chk("u1_checksum", checksum1, exp_sum);
`else
      chk("checksum", checksum, 0);
`endif
      for (int i = 0; i < 256; i++) chk("ram_contents", ram[i], rom[i]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ram_ack = 1'($urandom);
         chk("done_cpu_ready", cpu_ready, 1);
         chk("done_ram_we", ram_we, 0);
         chk("done_rom_cs", rom_cs, 0);
      end
   endtask

   initial begin
      tbl[0] = '{via_start: 0, pat: 0, stall_mode: 0, rand_start: 0, abort_at: -1, exp_cycles: 769, exp_sum: 8'h80};
      tbl[1] = '{via_start: 1, pat: 0, stall_mode: 0, rand_start: 1, abort_at: -1, exp_cycles: 769, exp_sum: 8'h80};
      tbl[2] = '{via_start: 1, pat: 1, stall_mode: 1, rand_start: 0, abort_at: -1, exp_cycles: 774, exp_sum: 8'h00};
      tbl[3] = '{via_start: 0, pat: 2, stall_mode: 0, rand_start: 0, abort_at: -1, exp_cycles: 769, exp_sum: 8'h10};
      tbl[4] = '{via_start: 1, pat: 3, stall_mode: 2, rand_start: 1, abort_at: -1, exp_cycles: -1, exp_sum: -1};
      tbl[5] = '{via_start: 0, pat: 0, stall_mode: 0, rand_start: 1, abort_at: 100, exp_cycles: 769, exp_sum: 8'h80};
      tbl[6] = '{via_start: 0, pat: 0, stall_mode: 0, rand_start: 0, abort_at: -1, exp_cycles: 769, exp_sum: 8'h80};
      for (int t = 0; t < 7; t++) begin
         if (tbl[t].via_start) begin
            @(negedge clk);
            start = 1'b1;
         end else do_reset();
         run_copy(tbl[t]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
